// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART bus master: command/reply codes, FSM
// state encoding and the reply checksum helper.
// Build option UART_BUS_MASTER_CSUM_EN adds the CMD_CSUM frame state.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_ADDR,
        S_CMD_DATA,
`ifdef UART_BUS_MASTER_CSUM_EN
        S_CMD_CSUM,
`endif
        S_BUS,
        S_REPLY
    } state_t;

    // XOR of the four bytes of a word, used as the read-reply checksum
    function automatic logic [7:0] xor4(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// picorv32 native memory bus as seen from one initiator port.
interface uart_bus_master_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, falling-edge start detection,
// mid-bit sampling and stop-bit check. Dropping en parks the receiver so
// that bytes arriving while the master is busy are simply lost.
module uart_byte_rx #(
    parameter int BAUD_DIVIDER = 694
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frm_err
);

    localparam int CW = $clog2(BAUD_DIVIDER + 1);

    logic [1:0]    sync_q;
    logic          rx_prev;
    logic          rx_s;
    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s = sync_q[1];

    // Synchronise the asynchronous line and keep last value for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            rx_prev <= rx_s;
        end
    end

    // Bit timing: half period to the start-bit centre, then one full period
    // per bit; bit_idx 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_frm_err <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_frm_err <= 1'b0;
            if (!en) begin
                active <= 1'b0;
            end else if (!active) begin
                if (rx_prev && !rx_s) begin
                    active  <= 1'b1;
                    cnt     <= CW'(BAUD_DIVIDER >> 1);
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                cnt     <= CW'(BAUD_DIVIDER);
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd0) begin
                    // line back high at the start-bit centre: glitch, rearm
                    if (rx_s) active <= 1'b0;
                end else if (bit_idx <= 4'd8) begin
                    shreg <= {rx_s, shreg[7:1]};
                end else begin
                    active <= 1'b0;
                    if (rx_s) begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                    end else begin
                        rx_frm_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART debug/loader bridge: decodes 'W'/'R' command frames from the host
// and performs one 32-bit picorv32 bus transaction per frame, replying
// with ACK/NAK or the read data.
// Build option UART_BUS_MASTER_CSUM_EN: host frames carry a trailing XOR
// checksum byte and read replies append the XOR of the four data bytes.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int          BAUD_DIVIDER = 694,
    parameter logic [31:0] BYTE_TIMEOUT = 32'd8_000_000,
    parameter logic [15:0] BUS_TIMEOUT  = 16'd1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rxd,
    output logic                uart_txd,
    output logic                busy,
    uart_bus_master_if.master   mem
);

    localparam int CW = $clog2(BAUD_DIVIDER + 1);

    // receiver
    logic       rx_en;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frm_err;

    // transmitter
    logic [9:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic          tx_act;
    logic          tx_ready;
    logic          tx_load;
    logic [7:0]    tx_byte;

    // frame / bus state
    state_t      state_q,   state_n;
    logic [1:0]  cnt_q,     cnt_n;
    logic        wr_q,      wr_n;
    logic [31:0] addr_q,    addr_n;
    logic [31:0] wdata_q,   wdata_n;
    logic [31:0] tout_q,    tout_n;
    logic [15:0] bus_cnt_q, bus_cnt_n;
    logic        valid_q,   valid_n;
    logic [39:0] rsp_q,     rsp_n;
    logic [2:0]  left_q,    left_n;
    logic        go_bus;
    logic        go_nak;
`ifdef UART_BUS_MASTER_CSUM_EN
    logic [7:0]  csum_q,    csum_n;
`endif

    // Host bytes are only taken while a frame can still be assembled
    assign rx_en = (state_q != S_BUS) && (state_q != S_REPLY);
    assign busy  = (state_q != S_IDLE);

    uart_byte_rx #(.BAUD_DIVIDER(BAUD_DIVIDER)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .en         (rx_en),
        .rxd        (uart_rxd),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_frm_err (rx_frm_err)
    );

    assign mem.mem_valid = valid_q;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = (valid_q && wr_q) ? 4'hF : 4'h0;

    // TX is ready either when idle or in the last cycle of a stop bit, which
    // lets the next reply byte follow with no idle gap
    assign tx_ready = !tx_act || (tx_cnt == '0 && tx_bits == 4'd0);
    assign uart_txd = tx_sh[0];

    // TX shifter: {stop, data, start}, shifted out LSB first, refilled with 1s
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_bits <= '0;
            tx_act  <= 1'b0;
        end else if (tx_load) begin
            tx_sh   <= {1'b1, tx_byte, 1'b0};
            tx_cnt  <= CW'(BAUD_DIVIDER);
            tx_bits <= 4'd9;
            tx_act  <= 1'b1;
        end else if (tx_act) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CW'(1);
            end else if (tx_bits == 4'd0) begin
                tx_act <= 1'b0;
            end else begin
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_bits <= tx_bits - 4'd1;
                tx_cnt  <= CW'(BAUD_DIVIDER);
            end
        end
    end

    // FSM and frame registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tout_q    <= '0;
            bus_cnt_q <= '0;
            valid_q   <= 1'b0;
            rsp_q     <= '0;
            left_q    <= '0;
`ifdef UART_BUS_MASTER_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            tout_q    <= tout_n;
            bus_cnt_q <= bus_cnt_n;
            valid_q   <= valid_n;
            rsp_q     <= rsp_n;
            left_q    <= left_n;
`ifdef UART_BUS_MASTER_CSUM_EN
            csum_q    <= csum_n;
`endif
        end
    end

    // Next-state: frame assembly, bus handshake, reply sequencing
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        wr_n      = wr_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        tout_n    = tout_q;
        bus_cnt_n = bus_cnt_q;
        valid_n   = valid_q;
        rsp_n     = rsp_q;
        left_n    = left_q;
        go_bus    = 1'b0;
        go_nak    = 1'b0;
        tx_load   = 1'b0;
        tx_byte   = rsp_q[7:0];
`ifdef UART_BUS_MASTER_CSUM_EN
        csum_n    = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_n  = '0;
                    tout_n = '0;
`ifdef UART_BUS_MASTER_CSUM_EN
                    csum_n = rx_data;
`endif
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        wr_n    = (rx_data == CMD_WR);
                        state_n = S_CMD_ADDR;
                    end else begin
                        go_nak = 1'b1;
                    end
                end
            end

            S_CMD_ADDR, S_CMD_DATA: begin
                if (rx_frm_err) begin
                    state_n = S_IDLE;
                end else if (rx_valid) begin
                    tout_n = '0;
                    cnt_n  = cnt_q + 2'd1;
                    // little-endian: bytes enter at the top and slide down
                    if (state_q == S_CMD_ADDR) addr_n  = {rx_data, addr_q[31:8]};
                    else                       wdata_n = {rx_data, wdata_q[31:8]};
`ifdef UART_BUS_MASTER_CSUM_EN
                    csum_n = csum_q ^ rx_data;
`endif
                    if (cnt_q == 2'd3) begin
                        if (state_q == S_CMD_ADDR && wr_q) begin
                            state_n = S_CMD_DATA;
                        end else begin
`ifdef UART_BUS_MASTER_CSUM_EN
                            state_n = S_CMD_CSUM;
`else
                            go_bus = 1'b1;
`endif
                        end
                    end
                end else if (tout_q == BYTE_TIMEOUT) begin
                    state_n = S_IDLE;
                end else begin
                    tout_n = tout_q + 32'd1;
                end
            end

`ifdef UART_BUS_MASTER_CSUM_EN
            S_CMD_CSUM: begin
                if (rx_frm_err) begin
                    state_n = S_IDLE;
                end else if (rx_valid) begin
                    if (rx_data == csum_q) go_bus = 1'b1;
                    else                   go_nak = 1'b1;
                end else if (tout_q == BYTE_TIMEOUT) begin
                    state_n = S_IDLE;
                end else begin
                    tout_n = tout_q + 32'd1;
                end
            end
`endif

            S_BUS: begin
                if (mem.mem_ready) begin
                    valid_n = 1'b0;
                    state_n = S_REPLY;
                    if (wr_q) begin
                        rsp_n  = {32'd0, RSP_ACK};
                        left_n = 3'd1;
                    end else begin
`ifdef UART_BUS_MASTER_CSUM_EN
                        rsp_n  = {xor4(mem.mem_rdata), mem.mem_rdata};
                        left_n = 3'd5;
`else
                        rsp_n  = {8'h00, mem.mem_rdata};
                        left_n = 3'd4;
`endif
                    end
                end else if (bus_cnt_q == BUS_TIMEOUT - 16'd1) begin
                    valid_n = 1'b0;
                    go_nak  = 1'b1;
                end else begin
                    bus_cnt_n = bus_cnt_q + 16'd1;
                end
            end

            S_REPLY: begin
                if (tx_ready) begin
                    if (left_q != 3'd0) begin
                        tx_load = 1'b1;
                        rsp_n   = {8'h00, rsp_q[39:8]};
                        left_n  = left_q - 3'd1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase

        if (go_bus) begin
            state_n   = S_BUS;
            valid_n   = 1'b1;
            bus_cnt_n = '0;
        end
        if (go_nak) begin
            state_n = S_REPLY;
            rsp_n   = {32'd0, RSP_NAK};
            left_n  = 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: host frames in, bus responder model,
// UART reply capture. Honours UART_BUS_MASTER_CSUM_EN when defined.
module tb_uart_bus_master;

    localparam int BIT  = 16;   // BAUD_DIVIDER 15
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    logic rxd;
    logic txd;
    logic busy;

    uart_bus_master_if bif();

    uart_bus_master #(
        .BAUD_DIVIDER (15),
        .BYTE_TIMEOUT (32'd2000),
        .BUS_TIMEOUT  (16'd1024)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (rxd),
        .uart_txd (txd),
        .busy     (busy),
        .mem      (bif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // responder model state
    int          resp_lat  = 0;
    logic [31:0] resp_data = '0;
    int          bus_count = 0;
    int          unstable  = 0;
    int          vcnt      = 0;
    int          vlen      = 0;
    int          last_vlen = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    logic [8:0] rxq[$];   // {stop, data} of each reply byte
    logic [7:0] txq[$];   // host frame being sent

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stp);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stp;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_raw();
        while (txq.size() > 0) send_byte(txq.pop_front(), 1'b1);
    endtask

    task automatic send_frame();
`ifdef UART_BUS_MASTER_CSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (txq[i]) x ^= txq[i];
        txq.push_back(x);
`endif
        send_raw();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic check_reply(input string tag, input int n, input logic [39:0] exp);
        check({tag, "_len"}, rxq.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rxq.size()) check($sformatf("%s_b%0d", tag, i), rxq[i], {1'b1, exp[8*i +: 8]});
        rxq.delete();
    endtask

    // Bus responder: acks resp_lat cycles into mem_valid (never if < 0),
    // records the request and watches that it stays stable
    initial begin
        bif.mem_ready = 1'b0;
        bif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                bif.mem_ready = 1'b0;
                vcnt = 0;
                vlen = 0;
            end else if (bif.mem_valid === 1'b1) begin
                vlen++;
                if (vcnt == 0) begin
                    bus_count++;
                    cap_addr  = bif.mem_addr;
                    cap_wdata = bif.mem_wdata;
                    cap_wstrb = bif.mem_wstrb;
                end else if (bif.mem_addr !== cap_addr || bif.mem_wdata !== cap_wdata ||
                             bif.mem_wstrb !== cap_wstrb) begin
                    unstable++;
                end
                if (bif.mem_ready) begin
                    bif.mem_ready = 1'b0;
                end else if (resp_lat >= 0 && vcnt == resp_lat) begin
                    bif.mem_ready = 1'b1;
                    bif.mem_rdata = resp_data;
                end
                vcnt++;
            end else begin
                bif.mem_ready = 1'b0;
                vcnt = 0;
                if (vlen != 0) last_vlen = vlen;
                vlen = 0;
            end
        end
    end

    // UART reply capture
    initial begin
        logic [7:0] b;
        logic       s;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd === 1'b0) begin
                repeat (HALF) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                s = txd;
                rxq.push_back({s, b});
            end
        end
    end

    initial begin
        int n;
        rxd   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd",   txd,            1'b1);
        check("rst_valid", bif.mem_valid,  1'b0);
        check("rst_addr",  bif.mem_addr,   32'h0);
        check("rst_wdata", bif.mem_wdata,  32'h0);
        check("rst_wstrb", bif.mem_wstrb,  4'h0);
        check("rst_busy",  busy,           1'b0);
        check("rst_instr", bif.mem_instr,  1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // write 0xDEADBEEF to 0x10
        resp_lat = 0;
        txq = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame();
        check("wr_busy", busy, 1'b1);
        wait_idle("wr_idle", 1000);
        check("wr_count", bus_count, 1);
        check("wr_addr",  cap_addr,  32'h0000_0010);
        check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", cap_wstrb, 4'hF);
        check_reply("wr_rsp", 1, 40'h06);
        check("wr_txd_idle", txd, 1'b1);
        bus_count = 0;
        repeat (20) @(negedge clk);

        // read from misaligned 0x13, responder answers after 3 cycles
        resp_lat  = 3;
        resp_data = 32'h1234_5678;
        txq = '{8'h52, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_idle("rd_idle", 2000);
        check("rd_count", bus_count, 1);
        check("rd_addr",  cap_addr,  32'h0000_0010);
        check("rd_wstrb", cap_wstrb, 4'h0);
`ifdef UART_BUS_MASTER_CSUM_EN
        check_reply("rd_rsp", 5, 40'h08_1234_5678);
`else
        check_reply("rd_rsp", 4, 40'h00_1234_5678);
`endif
        bus_count = 0;
        repeat (20) @(negedge clk);

        // unknown command
        send_byte(8'h41, 1'b1);
        wait_idle("bad_idle", 1000);
        check("bad_count", bus_count, 0);
        check_reply("bad_rsp", 1, 40'h15);
        repeat (20) @(negedge clk);

        // framing error on the 4th address byte, then a clean read
        txq = '{8'h52, 8'h10, 8'h00, 8'h00};
        send_raw();
        send_byte(8'h00, 1'b0);
        repeat (100) @(negedge clk);
        check("frm_busy",  busy,        1'b0);
        check("frm_count", bus_count,   0);
        check("frm_rsp",   rxq.size(),  0);
        resp_lat  = 1;
        resp_data = 32'hA5A5_0F0F;
        txq = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_idle("frm_rd_idle", 2000);
        check("frm_rd_count", bus_count, 1);
        check("frm_rd_addr",  cap_addr,  32'h0000_0020);
`ifdef UART_BUS_MASTER_CSUM_EN
        check_reply("frm_rd_rsp", 5, 40'h00_A5A5_0F0F);
`else
        check_reply("frm_rd_rsp", 4, 40'h00_A5A5_0F0F);
`endif
        bus_count = 0;
        repeat (20) @(negedge clk);

        // bus timeout: no mem_ready at all
        resp_lat  = -1;
        last_vlen = 0;
        txq = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_idle("bto_idle", 3000);
        check("bto_count", bus_count, 1);
        check("bto_vlen",  last_vlen, 1024);
        check_reply("bto_rsp", 1, 40'h15);
        bus_count = 0;
        repeat (20) @(negedge clk);

        // reset during the start bit of the second reply byte
        resp_lat  = 0;
        resp_data = 32'h1122_3344;
        txq = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        send_frame();
        n = 0;
        while (rxq.size() < 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mrst_first", rxq.size(), 1);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mrst_start", txd, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_txd",   txd,           1'b1);
        check("mrst_busy",  busy,          1'b0);
        check("mrst_valid", bif.mem_valid, 1'b0);
        check("mrst_addr",  bif.mem_addr,  32'h0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        rxq.delete();
        bus_count = 0;

        // byte timeout: frame stalls after two address bytes
        txq = '{8'h57, 8'h10, 8'h00};
        send_raw();
        repeat (1900) @(negedge clk);
        check("bt_busy_hold", busy, 1'b1);
        repeat (200) @(negedge clk);
        check("bt_busy_drop", busy, 1'b0);
        check("bt_count", bus_count, 0);
        check("bt_rsp",   rxq.size(), 0);

`ifdef UART_BUS_MASTER_CSUM_EN
        // wrong checksum (correct would be 0x76), then the right one
        txq = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h77};
        send_raw();
        wait_idle("cs_bad_idle", 1000);
        check("cs_bad_count", bus_count, 0);
        check_reply("cs_bad_rsp", 1, 40'h15);
        repeat (20) @(negedge clk);
        txq = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h76};
        send_raw();
        wait_idle("cs_ok_idle", 1000);
        check("cs_ok_count", bus_count, 1);
        check("cs_ok_wdata", cap_wdata, 32'h0000_0001);
        check_reply("cs_ok_rsp", 1, 40'h06);
`endif

        check("bus_stable", unstable, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
